// File: rtl/graphics_pkg.sv
// Shared graphics types and constants.
//   vec4_t       : four fp32 lanes, [0]=x .. [3]=w
//   mat4_t       : four rows of vec4_t, row k element j is m[k][j]
//   FP32_ONE     : 1.0 in IEEE-754 single precision
//   MATRIX_BEATS : number of row beats per matrix load
package graphics_pkg;

   typedef logic [3:0][31:0] vec4_t;
   typedef vec4_t [3:0]      mat4_t;

   localparam logic [31:0] FP32_ONE     = 32'h3F800000;
   localparam int          MATRIX_BEATS = 4;

endpackage

// File: rtl/fp32_dot.sv
// Pipelined fp32 four-element dot product, round-to-nearest-even.
// Ports:
//   clk_in  : clock
//   rst_in  : async active-low reset, clears every pipeline register
//   a_in    : first operand vector
//   b_in    : second operand vector
//   dot_out : ((a0*b0 + a1*b1) + (a2*b2 + a3*b3)), LATENCY cycles after the inputs
// Each multiply and add rounds to fp32. Subnormal inputs and results are
// flushed to signed zero; exponent overflow saturates to infinity.
module fp32_dot
   import graphics_pkg::*;
#(
   parameter int LATENCY = 12
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  vec4_t       a_in,
   input  vec4_t       b_in,
   output logic [31:0] dot_out
);

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sign;
      logic [23:0] ma;
      logic [23:0] mb;
      logic [47:0] p;
      logic [24:0] m;
      logic        g;
      logic        st;
      int          e;
      sign = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      p  = 48'(ma) * 48'(mb);
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m  = {1'b0, p[47:24]};
         g  = p[23];
         st = |p[22:0];
         e  = e + 1;
      end else begin
         m  = {1'b0, p[46:23]};
         g  = p[22];
         st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {sign, 8'hFF, 23'd0};
      if (e <= 0)   return {sign, 31'd0};
      return {sign, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x;
      logic [31:0] y;
      logic [26:0] mx;
      logic [26:0] my;
      logic [26:0] sh;
      logic [27:0] s;
      logic [24:0] m;
      logic        lost;
      logic        g;
      logic        st;
      int          e;
      int          d;
      // x is the larger magnitude, so the result takes its sign
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      // three extra low bits: guard, round, sticky
      mx   = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
      my   = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
      d    = int'(x[30:23]) - int'(y[30:23]);
      sh   = my >> d;
      lost = ((sh << d) != my);
      sh[0] = sh[0] | lost;
      if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
      else                s = {1'b0, mx} - {1'b0, sh};
      // exact cancellation gives +0; two zeros keep a shared negative sign
      if (s == 28'd0) return {x[31] & y[31], 31'd0};
      e = int'(x[30:23]);
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
               s = s << 1;
               e = e - 1;
            end
         end
      end
      m  = {1'b0, s[26:3]};
      g  = s[2];
      st = s[1] | s[0];
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {x[31], 8'hFF, 23'd0};
      if (e <= 0)   return {x[31], 31'd0};
      return {x[31], 8'(e), m[22:0]};
   endfunction

   // three arithmetic stages, then a delay tail so the total equals LATENCY
   logic [3:0][31:0]         prod_q, prod_d;
   logic [1:0][31:0]         sum_q, sum_d;
   logic [LATENCY-3:0][31:0] dly_q, dly_d;

   always_comb begin
      for (int k = 0; k < 4; k++) prod_d[k] = fp_mul(a_in[k], b_in[k]);
      sum_d[0] = fp_add(prod_q[0], prod_q[1]);
      sum_d[1] = fp_add(prod_q[2], prod_q[3]);
      dly_d    = dly_q;
      dly_d[0] = fp_add(sum_q[0], sum_q[1]);
      for (int i = 1; i <= LATENCY - 3; i++) dly_d[i] = dly_q[i-1];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         prod_q <= '0;
         sum_q  <= '0;
         dly_q  <= '0;
      end else begin
         prod_q <= prod_d;
         sum_q  <= sum_d;
         dly_q  <= dly_d;
      end
   end

   assign dot_out = dly_q[LATENCY-3];

endmodule

// File: rtl/matrix_loader.sv
// Double-buffered 4x4 matrix loader fed by a four-beat row stream.
// Ports:
//   clk_in       : clock
//   rst_in       : async active-low reset (clears beat counter and loaded flag)
//   row_valid_in : one row beat present
//   row_in       : row data for the current beat
//   matrix_out   : active (committed) matrix
//   loaded_out   : a complete matrix has been committed since reset
// Rows 0..2 are held in the shadow bank. The row-3 beat goes straight into
// the active bank together with the shadow rows, so the new matrix is
// visible from the cycle after that beat and a partial load never touches it.
module matrix_loader
   import graphics_pkg::*;
(
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  row_valid_in,
   input  vec4_t row_in,
   output mat4_t matrix_out,
   output logic  loaded_out
);

   localparam logic [1:0] LAST_BEAT = 2'(MATRIX_BEATS - 1);

   logic [1:0]  beat_q, beat_d;
   logic        loaded_q, loaded_d;
   vec4_t [2:0] shadow_q, shadow_d;
   mat4_t       active_q, active_d;

   always_comb begin
      beat_d   = beat_q;
      loaded_d = loaded_q;
      shadow_d = shadow_q;
      active_d = active_q;
      if (row_valid_in) begin
         beat_d = beat_q + 2'd1;
         if (beat_q == LAST_BEAT) begin
            active_d = {row_in, shadow_q};
            loaded_d = 1'b1;
         end else begin
            shadow_d[beat_q] = row_in;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         beat_q   <= 2'd0;
         loaded_q <= 1'b0;
      end else begin
         beat_q   <= beat_d;
         loaded_q <= loaded_d;
      end
   end

   // bank contents are qualified by loaded_q, so they need no reset
   always_ff @(posedge clk_in) begin
      shadow_q <= shadow_d;
      active_q <= active_d;
   end

   assign matrix_out = active_q;
   assign loaded_out = loaded_q;

endmodule

// File: rtl/view_transform.sv
// Applies a streamed 4x4 fp32 view matrix to a stream of homogeneous vertices.
// Ports:
//   clk_in           : clock
//   rst_in           : async active-low reset
//   matrix_valid_in  : matrix row beat present
//   row_in           : matrix row, [j] = m[k][j]
//   vertex_valid_in  : vertex present
//   vertex_in        : vertex {w,z,y,x}
//   vertex_ready_out : a committed matrix exists; vertices are dropped otherwise
//   valid_out        : transformed vertex valid
//   vertex_out       : component k = dot(m[k], vertex)
// Latency is DOT_LATENCY + 1 cycles from the presenting cycle; one vertex
// per cycle, no backpressure.
module view_transform
   import graphics_pkg::*;
#(
   parameter int DOT_LATENCY = 12
) (
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  matrix_valid_in,
   input  vec4_t row_in,
   input  logic  vertex_valid_in,
   input  vec4_t vertex_in,
   output logic  vertex_ready_out,
   output logic  valid_out,
   output vec4_t vertex_out
);

   mat4_t active_m;
   logic  loaded;
   logic  accept;

   matrix_loader u_loader (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .row_valid_in (matrix_valid_in),
      .row_in       (row_in),
      .matrix_out   (active_m),
      .loaded_out   (loaded)
   );

   assign accept = vertex_valid_in && loaded;

   // stage 0 snapshots the matrix with the vertex, so later commits cannot
   // affect vertices already accepted
   vec4_t                  vtx_q, vtx_d;
   mat4_t                  mat_q, mat_d;
   logic                   v0_q, v0_d;
   logic [DOT_LATENCY-1:0] valid_pipe_q, valid_pipe_d;

   always_comb begin
      vtx_d = vtx_q;
      mat_d = mat_q;
      if (accept) begin
         vtx_d = vertex_in;
         mat_d = active_m;
      end
      v0_d         = accept;
      valid_pipe_d = {valid_pipe_q[DOT_LATENCY-2:0], v0_q};
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         v0_q         <= 1'b0;
         valid_pipe_q <= '0;
      end else begin
         v0_q         <= v0_d;
         valid_pipe_q <= valid_pipe_d;
      end
   end

   always_ff @(posedge clk_in) begin
      vtx_q <= vtx_d;
      mat_q <= mat_d;
   end

   for (genvar k = 0; k < 4; k++) begin : g_dot
      fp32_dot #(.LATENCY(DOT_LATENCY)) u_dot (
         .clk_in  (clk_in),
         .rst_in  (rst_in),
         .a_in    (mat_q[k]),
         .b_in    (vtx_q),
         .dot_out (vertex_out[k])
      );
   end

   assign vertex_ready_out = loaded;
   assign valid_out        = valid_pipe_q[DOT_LATENCY-1];

endmodule

// File: tb/tb_view_transform.sv
// Scoreboard bench for view_transform: stimulus pushes expected results
// computed from real-valued matrix arithmetic; a monitor pops and compares.
module tb_view_transform;
   import graphics_pkg::*;

   localparam int L = 12;

   logic  clk_in = 1'b0;
   logic  rst_in = 1'b0;
   logic  matrix_valid_in = 1'b0;
   vec4_t row_in = '0;
   logic  vertex_valid_in = 1'b0;
   vec4_t vertex_in = '0;
   logic  vertex_ready_out;
   logic  valid_out;
   vec4_t vertex_out;

   view_transform #(.DOT_LATENCY(L)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .matrix_valid_in  (matrix_valid_in),
      .row_in           (row_in),
      .vertex_valid_in  (vertex_valid_in),
      .vertex_in        (vertex_in),
      .vertex_ready_out (vertex_ready_out),
      .valid_out        (valid_out),
      .vertex_out       (vertex_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      vec4_t data;
      int    cyc;
   } exp_t;

   exp_t  exp_q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    n_out = 0;
   real   act_m[4][4];
   real   load_m[4][4];
   bit    model_loaded = 1'b0;
   bit    ovr_en = 1'b0;
   vec4_t ovr_val;
   real   zv[4] = '{0.0, 0.0, 0.0, 0.0};

   function automatic logic [31:0] to_f32(input real r);
      logic [63:0] b;
      int          e;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) return {b[63], 31'd0};
      e = int'(b[62:52]) - 1023 + 127;
      return {b[63], 8'(e), b[51:29]};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_in === 1'b1 && valid_out === 1'b1) begin
         exp_t e;
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_output", 128'(valid_out), 128'd0);
         end else begin
            e = exp_q.pop_front();
            check("vertex_out", vertex_out, e.data);
            check("output_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   // one stimulus cycle; called just after a rising edge
   task automatic drive(input bit beat, input int k, input bit vtx, input real vx[4]);
      vec4_t r;
      vec4_t v;
      exp_t  e;
      real   acc;
      for (int j = 0; j < 4; j++) begin
         r[j] = to_f32(load_m[k][j]);
         v[j] = to_f32(vx[j]);
      end
      matrix_valid_in = beat;
      row_in          = r;
      vertex_valid_in = vtx;
      vertex_in       = v;
      if (vtx && model_loaded) begin
         for (int kk = 0; kk < 4; kk++) begin
            acc = act_m[kk][0] * vx[0];
            for (int j = 1; j < 4; j++) acc = acc + act_m[kk][j] * vx[j];
            e.data[kk] = to_f32(acc);
         end
         if (ovr_en) e.data = ovr_val;
         e.cyc = cyc + L + 1;
         exp_q.push_back(e);
      end
      ovr_en = 1'b0;
      if (beat && k == 3) begin
         act_m        = load_m;
         model_loaded = 1'b1;
      end
      @(posedge clk_in);
      #1;
      matrix_valid_in = 1'b0;
      vertex_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0, zv);
   endtask

   task automatic load_matrix(input int gap);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k, 1'b0, zv);
         idle(gap);
      end
   endtask

   task automatic set_translation();
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) load_m[k][j] = (k == j) ? 1.0 : 0.0;
      load_m[0][3] = 2.0;
      load_m[1][3] = 3.0;
      load_m[2][3] = 4.0;
   endtask

   task automatic set_scale();
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) load_m[k][j] = (k == j) ? ((k == 3) ? 1.0 : 2.0) : 0.0;
   endtask

   // small multiples of 0.5 keep every product and sum exact in fp32
   task automatic rand_matrix();
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            load_m[k][j] = real'(int'($urandom_range(0, 16)) - 8) * 0.5;
   endtask

   task automatic rand_vec(output real v[4]);
      for (int j = 0; j < 4; j++) v[j] = real'(int'($urandom_range(0, 32)) - 16) * 0.5;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      exp_q.delete();
      model_loaded = 1'b0;
      idle(2);
      rst_in = 1'b1;
      idle(1);
   endtask

   initial begin
      real v[4];
      int  next_k;
      bit  beat;

      repeat (3) @(posedge clk_in);
      #1;
      check("reset_ready", 128'(vertex_ready_out), 128'd0);
      check("reset_valid", 128'(valid_out), 128'd0);
      check("reset_vertex_out", vertex_out, 128'd0);
      rst_in = 1'b1;
      idle(2);

      // no matrix loaded: vertex dropped
      v = '{1.0, 1.0, 1.0, 1.0};
      drive(1'b0, 0, 1'b1, v);
      check("ready_unloaded", 128'(vertex_ready_out), 128'd0);
      idle(L + 4);
      check("no_matrix_outputs", 128'(n_out), 128'd0);

      // translation
      set_translation();
      for (int k = 0; k < 3; k++) drive(1'b1, k, 1'b0, zv);
      check("ready_before_commit", 128'(vertex_ready_out), 128'd0);
      drive(1'b1, 3, 1'b0, zv);
      check("ready_after_commit", 128'(vertex_ready_out), 128'd1);
      ovr_en  = 1'b1;
      ovr_val = {32'h3F800000, 32'h40A00000, 32'h40800000, 32'h40400000};
      drive(1'b0, 0, 1'b1, v);
      idle(L + 3);

      // scale with gappy load
      set_scale();
      load_matrix(3);
      ovr_en  = 1'b1;
      ovr_val = {32'h3F800000, 32'h3F800000, 32'hC0800000, 32'h40400000};
      v = '{1.5, -2.0, 0.5, 1.0};
      drive(1'b0, 0, 1'b1, v);
      idle(L + 3);

      // swap mid-stream: beat 3 coincides with vertex 5
      set_translation();
      load_matrix(0);
      set_scale();
      for (int i = 0; i < 10; i++) begin
         rand_vec(v);
         beat = (i >= 2 && i <= 5);
         drive(beat, beat ? i - 2 : 0, 1'b1, v);
      end
      idle(L + 3);

      // reset mid-pipeline and mid-load
      rand_matrix();
      for (int k = 0; k < 3; k++) begin
         rand_vec(v);
         drive(1'b1, k, 1'b1, v);
      end
      do_reset();
      check("ready_after_reset", 128'(vertex_ready_out), 128'd0);
      rand_matrix();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) check("ready_reload_partial", 128'(vertex_ready_out), 128'd0);
         rand_vec(v);
         drive(1'b1, k, 1'b1, v);
      end
      check("ready_reload_done", 128'(vertex_ready_out), 128'd1);
      for (int i = 0; i < 8; i++) begin
         rand_vec(v);
         drive(1'b0, 0, 1'b1, v);
      end
      idle(L + 3);

      // throughput
      set_translation();
      load_matrix(0);
      for (int i = 0; i < 64; i++) begin
         rand_vec(v);
         drive(1'b0, 0, 1'b1, v);
      end
      idle(L + 3);

      // random interleaving of loads and vertices
      next_k = 0;
      for (int i = 0; i < 400; i++) begin
         beat = ($urandom_range(0, 2) == 0);
         if (beat && next_k == 0) rand_matrix();
         rand_vec(v);
         drive(beat, next_k, ($urandom_range(0, 3) != 0), v);
         if (beat) next_k = (next_k + 1) % 4;
      end
      idle(L + 5);
      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
